// File: rtl/counter_cmd_ctrl.sv
// counter_cmd_ctrl: button front end for the up/down/load counter.
// Synchronises and debounces three raw buttons, arbitrates load > down > up,
// and issues one single-cycle command per press. load_val is captured from SW
// on the edge a load command issues.
// Optional feature: define AUTO_REPEAT_EN to re-issue held up/down commands.
module counter_cmd_ctrl #(
    parameter int W          = 8,
    parameter int DEB_CYCLES = 4,
    parameter int REP_DELAY  = 8,
    parameter int REP_RATE   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_load,
    input  logic [W-1:0] SW,
    output logic         cnt_up,
    output logic         cnt_down,
    output logic         cnt_load,
    output logic [W-1:0] load_val,
    output logic         busy
);

    localparam int DW = $clog2(DEB_CYCLES);

    // Button index: 0 = up, 1 = down, 2 = load.
    typedef enum logic [1:0] {SEL_UP = 2'd0, SEL_DOWN = 2'd1, SEL_LOAD = 2'd2} sel_t;

`ifdef AUTO_REPEAT_EN
    typedef enum logic [1:0] {IDLE, ISSUE, HOLD, REPEAT} state_t;
    localparam int RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int RW   = $clog2(RMAX);
    logic [RW-1:0] rep_cnt;
`else
    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
`endif

    logic [2:0]    btn;
    logic [2:0]    s1;
    logic [2:0]    deb;
    logic [2:0]    deb_q;
    logic [2:0]    deb_nxt;
    logic [2:0]    req;
    logic [DW-1:0] deb_cnt [3];
    state_t        state, state_nxt;
    sel_t          sel, sel_nxt;
    logic          cap;
    logic          win_deb;
    logic          win_deb_nxt;
    logic          pulse;

    assign btn = {btn_load, btn_down, btn_up};

    // Next debounced level: flips on the DEB_CYCLES-th consecutive sample that disagrees.
    always_comb begin
        deb_nxt = deb;
        for (int i = 0; i < 3; i++) begin
            if (s1[i] != deb[i] && deb_cnt[i] == DW'(DEB_CYCLES - 1))
                deb_nxt[i] = ~deb[i];
        end
    end

    // Synchroniser stage, debounce counters and debounced levels. The deb flop
    // re-times s1, so the filtered level is two flops away from the pad.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1    <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            s1    <= btn;
            deb   <= deb_nxt;
            deb_q <= deb;
            for (int i = 0; i < 3; i++) begin
                if (s1[i] == deb[i] || deb_cnt[i] == DW'(DEB_CYCLES - 1))
                    deb_cnt[i] <= '0;
                else
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
        end
    end

    assign req = deb & ~deb_q;

    // Debounced level of the button that won arbitration.
    always_comb begin
        win_deb     = 1'b0;
        win_deb_nxt = 1'b0;
        case (sel)
            SEL_UP:   begin win_deb = deb[0]; win_deb_nxt = deb_nxt[0]; end
            SEL_DOWN: begin win_deb = deb[1]; win_deb_nxt = deb_nxt[1]; end
            SEL_LOAD: begin win_deb = deb[2]; win_deb_nxt = deb_nxt[2]; end
            default:  begin win_deb = 1'b0;   win_deb_nxt = 1'b0;       end
        endcase
    end

    // State, winner and captured operand registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            sel      <= SEL_UP;
            load_val <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            if (cap) load_val <= SW;
        end
    end

    // Next state: arbitrate in IDLE, pulse once, then hold until the winner is released.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        cap       = 1'b0;
        case (state)
            IDLE: begin
                if (req[2]) begin
                    state_nxt = ISSUE;
                    sel_nxt   = SEL_LOAD;
                    cap       = 1'b1;
                end else if (req[1]) begin
                    state_nxt = ISSUE;
                    sel_nxt   = SEL_DOWN;
                end else if (req[0]) begin
                    state_nxt = ISSUE;
                    sel_nxt   = SEL_UP;
                end
            end
            ISSUE: state_nxt = HOLD;
            HOLD: begin
                if (!win_deb)
                    state_nxt = IDLE;
`ifdef AUTO_REPEAT_EN
                // A repeat landing on the edge the button debounces low is dropped.
                else if (sel != SEL_LOAD && rep_cnt == '0 && win_deb_nxt)
                    state_nxt = REPEAT;
`endif
            end
`ifdef AUTO_REPEAT_EN
            REPEAT: state_nxt = HOLD;
`endif
            default: state_nxt = IDLE;
        endcase
    end

`ifdef AUTO_REPEAT_EN
    // Repeat spacing: reload on each pulse, count down while holding.
    // Loaded with N-2 because the pulse cycle and the exit edge each take one cycle.
    always_ff @(posedge clk) begin
        if (!rst)
            rep_cnt <= '0;
        else if (state == ISSUE)
            rep_cnt <= RW'(REP_DELAY - 2);
        else if (state == REPEAT)
            rep_cnt <= RW'(REP_RATE - 2);
        else if (state == HOLD && rep_cnt != '0)
            rep_cnt <= rep_cnt - 1'b1;
    end
    assign pulse = (state == ISSUE) || (state == REPEAT);
`else
    assign pulse = (state == ISSUE);
`endif

    assign cnt_up   = pulse && (sel == SEL_UP);
    assign cnt_down = pulse && (sel == SEL_DOWN);
    assign cnt_load = pulse && (sel == SEL_LOAD);
    assign busy     = (state != IDLE);

    // win_deb_nxt only steers the repeat decision.
    logic unused_ok;
    assign unused_ok = win_deb_nxt;

endmodule
